// File: rtl/gshare_pht.sv
// gshare pattern history table: fetch predicts from pc^history, the index and
// prediction ride through decode/execute where the resolved outcome trains.
module gshare_pht #(
   parameter int W  = 3,
   parameter int CW = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  pc_f,
   input  logic [W-1:0] ghr,
   input  logic         stall_d,
   input  logic         flush_d,
   input  logic         flush_e,
   input  logic         branch_e,
   input  logic         taken_e,
   output logic         pred_taken_f,
   output logic         pred_taken_e,
   output logic         mispredict_e,
   output logic [W-1:0] idx_e
);
   localparam int N = 1 << W;

   function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
      logic [1:0] res;
      if (up) begin
         res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end else begin
         res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
      return res;
   endfunction

   logic [CW-1:0] pht_q [N];
   logic [W-1:0]  idx_f_s;
   logic          valid_dec_q, valid_dec_d;
   logic [W-1:0]  idx_dec_q, idx_dec_d;
   logic          pred_dec_q, pred_dec_d;
   logic          valid_ex_q, valid_ex_d;
   logic [W-1:0]  idx_ex_q, idx_ex_d;
   logic          pred_ex_q, pred_ex_d;
   logic          upd_en_s;
   logic [CW-1:0] upd_cnt_s;
   logic          unused_pc_s;

   assign idx_f_s      = pc_f[W+1:2] ^ ghr;
   assign pred_taken_f = pht_q[idx_f_s][1];
   assign unused_pc_s  = ^{pc_f[31:W+2], pc_f[1:0]};

   // Decode slot: flush beats stall, stall holds every field.
   always_comb begin
      valid_dec_d = valid_dec_q;
      idx_dec_d   = idx_dec_q;
      pred_dec_d  = pred_dec_q;
      if (flush_d) begin
         valid_dec_d = 1'b0;
      end else if (stall_d) begin
         valid_dec_d = valid_dec_q;
      end else begin
         valid_dec_d = 1'b1;
         idx_dec_d   = idx_f_s;
         pred_dec_d  = pred_taken_f;
      end
   end

   // Execute slot: never stalls, only a flush turns it into a bubble.
   always_comb begin
      valid_ex_d = valid_dec_q;
      idx_ex_d   = idx_dec_q;
      pred_ex_d  = pred_dec_q;
      if (flush_e) begin
         valid_ex_d = 1'b0;
         idx_ex_d   = idx_ex_q;
         pred_ex_d  = pred_ex_q;
      end else begin
         valid_ex_d = valid_dec_q;
      end
   end

   // Training uses the fetch-time index carried in execute, never a recomputed one.
   always_comb begin
      upd_en_s  = valid_ex_q & branch_e;
      upd_cnt_s = sat_step(pht_q[idx_ex_q], taken_e);
   end

   // Pipeline slot registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_dec_q <= 1'b0;
         idx_dec_q   <= '0;
         pred_dec_q  <= 1'b0;
         valid_ex_q  <= 1'b0;
         idx_ex_q    <= '0;
         pred_ex_q   <= 1'b0;
      end else begin
         valid_dec_q <= valid_dec_d;
         idx_dec_q   <= idx_dec_d;
         pred_dec_q  <= pred_dec_d;
         valid_ex_q  <= valid_ex_d;
         idx_ex_q    <= idx_ex_d;
         pred_ex_q   <= pred_ex_d;
      end
   end

   // Counter table, reset to weakly not-taken; one entry written per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            pht_q[i] <= 2'b01;
         end
      end else if (upd_en_s) begin
         pht_q[idx_ex_q] <= upd_cnt_s;
      end else begin
         pht_q[idx_ex_q] <= pht_q[idx_ex_q];
      end
   end

   assign pred_taken_e = pred_ex_q;
   assign idx_e        = idx_ex_q;
   assign mispredict_e = valid_ex_q & branch_e & (taken_e ^ pred_ex_q);

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht: reset, xor indexing, training, saturation,
// stall/flush and asynchronous reset with hand-computed expectations.
module tb_gshare_pht;
   logic        clk;
   logic        reset;
   logic [31:0] pc_f;
   logic [2:0]  ghr;
   logic        stall_d, flush_d, flush_e, branch_e, taken_e;
   logic        pred_taken_f, pred_taken_e, mispredict_e;
   logic [2:0]  idx_e;

   int n_checks = 0;
   int n_errors = 0;

   gshare_pht #(.W(3), .CW(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_f         (pc_f),
      .ghr          (ghr),
      .stall_d      (stall_d),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .branch_e     (branch_e),
      .taken_e      (taken_e),
      .pred_taken_f (pred_taken_f),
      .pred_taken_e (pred_taken_e),
      .mispredict_e (mispredict_e),
      .idx_e        (idx_e)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch one branch, walk it to execute, resolve it, and let the update land.
   task automatic run_branch(input logic [31:0] pc, input logic [2:0] g, input logic tk,
                             input logic exp_pf, input logic exp_mis, input string tag);
      logic [2:0] exp_idx;
      exp_idx  = pc[4:2] ^ g;
      pc_f     = pc;
      ghr      = g;
      branch_e = 1'b0;
      #1 check_val({tag, ".pred_f"}, {31'd0, pred_taken_f}, {31'd0, exp_pf});
      tick();
      tick();
      branch_e = 1'b1;
      taken_e  = tk;
      #1;
      check_val({tag, ".pred_e"}, {31'd0, pred_taken_e}, {31'd0, exp_pf});
      check_val({tag, ".mis"}, {31'd0, mispredict_e}, {31'd0, exp_mis});
      check_val({tag, ".idx_e"}, {29'd0, idx_e}, {29'd0, exp_idx});
      tick();
      branch_e = 1'b0;
      taken_e  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; pc_f = 32'h0000_0008; ghr = 3'b000;
      stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
      branch_e = 1'b1; taken_e = 1'b1;

      // reset held across edges with a would-be update present
      tick();
      tick();
      check_val("rst.pred_f", {31'd0, pred_taken_f}, 32'd0);
      check_val("rst.mis", {31'd0, mispredict_e}, 32'd0);
      check_val("rst.idx_e", {29'd0, idx_e}, 32'd0);
      check_val("rst.pred_e", {31'd0, pred_taken_e}, 32'd0);
      reset = 1'b1;
      branch_e = 1'b0; taken_e = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 8; i++) begin
         pc_f = 32'(i) << 2;
         ghr  = 3'b000;
         #1;
         check_val($sformatf("sweep%0d.pred_f", i), {31'd0, pred_taken_f}, 32'd0);
         check_val($sformatf("sweep%0d.cnt", i), {30'd0, dut.pht_q[i]}, 32'd1);
      end

      // xor indexing
      pc_f = 32'h0000_0008; ghr = 3'b010;
      tick(); tick();
      check_val("xor.g2", {29'd0, idx_e}, 32'd0);
      ghr = 3'b000;
      tick(); tick();
      check_val("xor.g0", {29'd0, idx_e}, 32'd2);

      // training on index 2
      run_branch(32'h0000_0008, 3'b000, 1'b1, 1'b0, 1'b1, "tr1");
      check_val("tr1.cnt", {30'd0, dut.pht_q[2]}, 32'd2);
      run_branch(32'h0000_0008, 3'b000, 1'b1, 1'b1, 1'b0, "tr2");
      check_val("tr2.cnt", {30'd0, dut.pht_q[2]}, 32'd3);
      pc_f = 32'h0000_0008;
      #1 check_val("tr2.after", {31'd0, pred_taken_f}, 32'd1);

      // saturation high then low
      for (int k = 0; k < 3; k++) begin
         run_branch(32'h0000_0008, 3'b000, 1'b1, 1'b1, 1'b0, $sformatf("sat%0d", k));
      end
      check_val("sat.cnt", {30'd0, dut.pht_q[2]}, 32'd3);
      run_branch(32'h0000_0008, 3'b000, 1'b0, 1'b1, 1'b1, "nt1");
      check_val("nt1.cnt", {30'd0, dut.pht_q[2]}, 32'd2);
      pc_f = 32'h0000_0008;
      #1 check_val("nt1.after", {31'd0, pred_taken_f}, 32'd1);
      run_branch(32'h0000_0008, 3'b000, 1'b0, 1'b1, 1'b1, "nt2");
      run_branch(32'h0000_0008, 3'b000, 1'b0, 1'b0, 1'b0, "nt3");
      run_branch(32'h0000_0008, 3'b000, 1'b0, 1'b0, 1'b0, "nt4");
      check_val("nt4.cnt", {30'd0, dut.pht_q[2]}, 32'd0);
      run_branch(32'h0000_0008, 3'b000, 1'b0, 1'b0, 1'b0, "nt5");
      check_val("nt5.cnt", {30'd0, dut.pht_q[2]}, 32'd0);

      // stall decode for two cycles while execute is flushed
      pc_f = 32'h0000_0010; ghr = 3'b000; flush_e = 1'b1;
      tick();
      stall_d = 1'b1; flush_e = 1'b1; pc_f = 32'h0000_0000;
      branch_e = 1'b1; taken_e = 1'b1;
      #1 check_val("stall1.mis", {31'd0, mispredict_e}, 32'd0);
      tick();
      #1 check_val("stall2.mis", {31'd0, mispredict_e}, 32'd0);
      tick();
      stall_d = 1'b0; flush_e = 1'b0; branch_e = 1'b0; taken_e = 1'b0;
      tick();
      check_val("stall.idx_held", {29'd0, idx_e}, 32'd4);
      check_val("stall.cnt4", {30'd0, dut.pht_q[4]}, 32'd1);
      check_val("stall.cnt0", {30'd0, dut.pht_q[0]}, 32'd1);
      pc_f = 32'h0000_0010;
      tick();

      // flush and stall together: flush wins, branch is dropped
      flush_d = 1'b1; stall_d = 1'b1;
      tick();
      check_val("fs.valid_d", {31'd0, dut.valid_dec_q}, 32'd0);
      flush_d = 1'b0; stall_d = 1'b0;
      tick();
      branch_e = 1'b1; taken_e = 1'b1;
      #1 check_val("fs.mis", {31'd0, mispredict_e}, 32'd0);
      tick();
      branch_e = 1'b0; taken_e = 1'b0;
      check_val("fs.cnt4", {30'd0, dut.pht_q[4]}, 32'd1);

      // asynchronous reset with a taken branch in execute
      run_branch(32'h0000_0014, 3'b000, 1'b1, 1'b0, 1'b1, "r5a");
      run_branch(32'h0000_0014, 3'b000, 1'b1, 1'b1, 1'b0, "r5b");
      check_val("r5.cnt", {30'd0, dut.pht_q[5]}, 32'd3);
      pc_f = 32'h0000_0014;
      tick(); tick();
      branch_e = 1'b1; taken_e = 1'b1;
      #1;
      check_val("ar.pre_mis", {31'd0, mispredict_e}, 32'd0);
      check_val("ar.pre_pred_e", {31'd0, pred_taken_e}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_val("ar.pred_f", {31'd0, pred_taken_f}, 32'd0);
      check_val("ar.pred_e", {31'd0, pred_taken_e}, 32'd0);
      check_val("ar.mis", {31'd0, mispredict_e}, 32'd0);
      check_val("ar.idx_e", {29'd0, idx_e}, 32'd0);
      tick();
      #2 reset = 1'b1;
      branch_e = 1'b0; taken_e = 1'b0;
      #1;
      check_val("ar.cnt5", {30'd0, dut.pht_q[5]}, 32'd1);
      check_val("ar.after_pred", {31'd0, pred_taken_f}, 32'd0);
      tick();
      check_val("ar.after_pred2", {31'd0, pred_taken_f}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
